assoc_dcache: RTL and testbench

ASSOC_DCACHE -- requirements
Module: assoc_dcache

---
 rtl/assoc_dcache.sv | 210 +++++++++++++++++++++
 tb/tb_assoc_dcache.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/assoc_dcache.sv
// assoc_dcache: 2-way set-associative, write-back, write-allocate data cache with a block-wide memory port.
// Defining DCACHE_PERF_EN adds the hit_cnt/miss_cnt performance counters.
module assoc_dcache #(
    parameter int SETS_LOG2  = 6,
    parameter int WORDS_LOG2 = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cpu_rd,
    input  logic                         cpu_wr,
    input  logic [31:0]                  cpu_addr,
    input  logic [31:0]                  cpu_wdata,
    output logic [31:0]                  cpu_rdata,
    output logic                         cpu_stall,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [31:0]                  mem_addr,
    output logic [(32<<WORDS_LOG2)-1:0]  mem_wdata,
    input  logic [(32<<WORDS_LOG2)-1:0]  mem_rdata,
    input  logic                         mem_ready
`ifdef DCACHE_PERF_EN
    ,
    output logic [31:0]                  hit_cnt,
    output logic [31:0]                  miss_cnt
`endif
);

    localparam int BLK_W = 32 << WORDS_LOG2;
    localparam int SETS  = 1 << SETS_LOG2;
    localparam int OFF_W = WORDS_LOG2 + 2;
    localparam int TAG_W = 30 - SETS_LOG2 - WORDS_LOG2;

    typedef enum logic [1:0] {
        IDLE,
        WBACK,
        FILL
    } state_t;

    state_t state_q, state_d;

    logic [TAG_W-1:0] tag_q  [2][SETS];
    logic [BLK_W-1:0] data_q [2][SETS];
    logic [SETS-1:0]  valid_q [2];
    logic [SETS-1:0]  dirty_q [2];
    logic [SETS-1:0]  lru_q;
    logic             victim_q, victim_d;

    logic [WORDS_LOG2-1:0] word;
    logic [SETS_LOG2-1:0]  set;
    logic [TAG_W-1:0]      tag;
    logic                  unused_addr;

    assign word        = cpu_addr[OFF_W-1:2];
    assign set         = cpu_addr[OFF_W +: SETS_LOG2];
    assign tag         = cpu_addr[31 -: TAG_W];
    assign unused_addr = ^cpu_addr[1:0];

    logic        req;
    logic        hit0, hit1, hit;
    logic        hit_way;
    logic        miss_victim;
    logic [31:0] hit_word;
    logic        hit_upd;
    logic        fill_we;
    logic        miss_det;

    assign req      = cpu_rd | cpu_wr;
    assign hit0     = valid_q[0][set] && (tag_q[0][set] == tag);
    assign hit1     = valid_q[1][set] && (tag_q[1][set] == tag);
    assign hit      = hit0 | hit1;
    // The two ways never share a tag, so way 1 matching is enough to pick it.
    assign hit_way  = hit1;
    assign hit_word = data_q[hit_way][set][{word, 5'b0} +: 32];

    always_comb begin
        if (!valid_q[0][set]) begin
            miss_victim = 1'b0;
        end else if (!valid_q[1][set]) begin
            miss_victim = 1'b1;
        end else begin
            miss_victim = lru_q[set];
        end
    end

    always_comb begin
        state_d   = state_q;
        victim_d  = victim_q;
        cpu_stall = 1'b0;
        cpu_rdata = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        hit_upd   = 1'b0;
        fill_we   = 1'b0;
        miss_det  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        hit_upd = 1'b1;
                        if (!cpu_wr) begin
                            cpu_rdata = hit_word;
                        end
                    end else begin
                        cpu_stall = 1'b1;
                        miss_det  = 1'b1;
                        victim_d  = miss_victim;
                        if (valid_q[miss_victim][set] && dirty_q[miss_victim][set]) begin
                            state_d = WBACK;
                        end else begin
                            state_d = FILL;
                        end
                    end
                end
            end
            WBACK: begin
                cpu_stall = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tag_q[victim_q][set], set, {OFF_W{1'b0}}};
                mem_wdata = data_q[victim_q][set];
                if (mem_ready) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                cpu_stall = 1'b1;
                mem_req   = 1'b1;
                mem_addr  = {cpu_addr[31:OFF_W], {OFF_W{1'b0}}};
                if (mem_ready) begin
                    fill_we = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Reset must silence the bus at once, even with a request still pending.
        if (rst) begin
            cpu_stall = 1'b0;
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            hit_upd   = 1'b0;
            fill_we   = 1'b0;
            miss_det  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            victim_q   <= 1'b0;
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            dirty_q[0] <= '0;
            dirty_q[1] <= '0;
            lru_q      <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            if (fill_we) begin
                valid_q[victim_q][set] <= 1'b1;
                dirty_q[victim_q][set] <= 1'b0;
            end
            if (hit_upd) begin
                lru_q[set] <= ~hit_way;
                if (cpu_wr) begin
                    dirty_q[hit_way][set] <= 1'b1;
                end
            end
        end
    end

    // Tag and data storage carry no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[victim_q][set]  <= tag;
            data_q[victim_q][set] <= mem_rdata;
        end else if (hit_upd && cpu_wr) begin
            data_q[hit_way][set][{word, 5'b0} +: 32] <= cpu_wdata;
        end
    end

`ifdef DCACHE_PERF_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_upd) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss_det) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    logic unused_miss_det;
    assign unused_miss_det = miss_det;
`endif

endmodule

// File: tb/tb_assoc_dcache.sv
// Self-checking bench for assoc_dcache: directed vector table, reset-in-FILL sequence,
// and random traffic checked against a flat-memory plus tag/LRU reference model.
module tb_assoc_dcache;

    localparam int BLK_W = 512;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_rd, cpu_wr;
    logic [31:0]       cpu_addr, cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_stall;
    logic              mem_req, mem_we;
    logic [31:0]       mem_addr;
    logic [BLK_W-1:0]  mem_wdata;
    logic [BLK_W-1:0]  mem_rdata;
    logic              mem_ready;
`ifdef DCACHE_PERF_EN
    logic [31:0]       hit_cnt, miss_cnt;
`endif

    assoc_dcache dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
`ifdef DCACHE_PERF_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Backing memory as the DUT sees it, and the CPU-visible view of memory.
    logic [31:0] bmem  [logic [31:0]];
    logic [31:0] cview [logic [31:0]];

    function automatic logic [31:0] pattern(logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] bread(logic [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return pattern(a);
    endfunction

    function automatic logic [31:0] vread(logic [31:0] a);
        if (cview.exists(a)) return cview[a];
        return bread(a);
    endfunction

    // Reference cache directory: which block address each way holds.
    bit          m_valid [2][64];
    bit          m_dirty [2][64];
    logic [31:0] m_blk   [2][64];
    int          m_lru   [64];
    int          m_hits, m_misses;

    task automatic m_reset();
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < 64; s++) begin
                m_valid[w][s] = 0;
                m_dirty[w][s] = 0;
            end
        for (int s = 0; s < 64; s++) m_lru[s] = 0;
        cview.delete();
        m_hits = 0;
        m_misses = 0;
    endtask

    task automatic m_access(input logic [31:0] a, input bit iswr, input logic [31:0] d,
                            output bit miss, output bit wb, output logic [31:0] wb_addr);
        int s, hw, v;
        logic [31:0] b;
        s  = int'((a >> 6) % 64);
        b  = a & ~32'h3F;
        hw = -1;
        miss = 0; wb = 0; wb_addr = '0;
        for (int w = 0; w < 2; w++)
            if (m_valid[w][s] && m_blk[w][s] == b) hw = w;
        if (hw < 0) begin
            miss = 1;
            m_misses++;
            if (!m_valid[0][s]) v = 0;
            else if (!m_valid[1][s]) v = 1;
            else v = m_lru[s];
            wb = m_valid[v][s] && m_dirty[v][s];
            wb_addr = m_blk[v][s];
            m_valid[v][s] = 1;
            m_dirty[v][s] = 0;
            m_blk[v][s] = b;
            hw = v;
        end
        m_hits++;
        m_lru[s] = 1 - hw;
        if (iswr) begin
            m_dirty[hw][s] = 1;
            cview[a & ~32'h3] = d;
        end
    endtask

    // Drive one CPU request, act as memory with the given latency, report what was observed.
    task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input int lat,
                          output logic [31:0] rdata, output bit miss, output bit wb,
                          output logic [31:0] wb_addr, output logic [31:0] wb_w1, output int cyc);
        int cnt;
        @(negedge clk);
        cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
        #1;
        miss = cpu_stall; wb = 0; wb_addr = '0; wb_w1 = '0; cyc = 0; cnt = 0;
        if (!cpu_stall) check("hit_no_memreq", {31'd0, mem_req}, 32'd0);
        while (cpu_stall && cyc < 100) begin
            if (mem_req) begin
                if (!mem_we) check("fill_addr", mem_addr, a & ~32'h3F);
                cnt++;
                if (cnt >= lat) begin
                    mem_ready = 1'b1;
                    cnt = 0;
                    if (mem_we) begin
                        wb = 1;
                        wb_addr = mem_addr;
                        wb_w1 = mem_wdata[63:32];
                        for (int i = 0; i < 16; i++) bmem[mem_addr + 32'(4*i)] = mem_wdata[32*i +: 32];
                    end else begin
                        for (int i = 0; i < 16; i++) mem_rdata[32*i +: 32] = bread(mem_addr + 32'(4*i));
                    end
                end
            end
            @(negedge clk);
            mem_ready = 1'b0;
            mem_rdata = {16{$urandom}};
            #1;
            cyc++;
        end
        if (cpu_stall) check("stall_timeout", 32'd1, 32'd0);
        rdata = cpu_rdata;
        @(negedge clk);
        cpu_rd = 1'b0; cpu_wr = 1'b0;
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          e_miss;
        bit          e_wb;
        logic [31:0] e_wb_addr;
        logic [31:0] e_wb_w1;
        bit          chk_rd;
        logic [31:0] e_rdata;
        int          e_cyc;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic [31:0] rdata, wb_addr, wb_w1, e_wb_addr;
        bit          miss, wb, e_miss, e_wb;
        int          cyc, lat, op;
        logic [31:0] a, d;

        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rdata, wb_addr, wb_w1, e_wb_addr, a, d;
        bit          miss, wb, e_miss, e_wb, rd, wr;
        int          cyc, lat, op;

        rst = 1'b1; cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        m_reset();
        bmem[32'h1000] = 32'hDEADBEEF;

        tbl[0] = '{1, 0, 32'h1000, 0, 1, 0, 0, 0, 1, 32'hDEADBEEF, 4};
        tbl[1] = '{0, 1, 32'h1004, 32'h12345678, 0, 0, 0, 0, 0, 0, 0};
        tbl[2] = '{1, 0, 32'h1004, 0, 0, 0, 0, 0, 1, 32'h12345678, 0};
        tbl[3] = '{1, 0, 32'h2000, 0, 1, 0, 0, 0, 1, pattern(32'h2000), 4};
        tbl[4] = '{1, 0, 32'h3000, 0, 1, 1, 32'h1000, 32'h12345678, 1, pattern(32'h3000), 7};

        repeat (3) @(negedge clk);
        #1;
        check("rst_stall", {31'd0, cpu_stall}, 32'd0);
        check("rst_memreq", {31'd0, mem_req}, 32'd0);
        check("rst_memwe", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_stall", {31'd0, cpu_stall}, 32'd0);
        check("idle_memreq", {31'd0, mem_req}, 32'd0);
        check("idle_rdata", cpu_rdata, 32'd0);

        for (int i = 0; i < 5; i++) begin
            access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, 3, rdata, miss, wb, wb_addr, wb_w1, cyc);
            m_access(tbl[i].addr, tbl[i].wr, tbl[i].wdata, e_miss, e_wb, e_wb_addr);
            check($sformatf("vec%0d_miss", i), {31'd0, miss}, {31'd0, tbl[i].e_miss});
            check($sformatf("vec%0d_wb", i), {31'd0, wb}, {31'd0, tbl[i].e_wb});
            check($sformatf("vec%0d_cycles", i), cyc, tbl[i].e_cyc);
            if (tbl[i].e_wb) begin
                check($sformatf("vec%0d_wb_addr", i), wb_addr, tbl[i].e_wb_addr);
                check($sformatf("vec%0d_wb_word1", i), wb_w1, tbl[i].e_wb_w1);
            end
            if (tbl[i].chk_rd) check($sformatf("vec%0d_rdata", i), rdata, tbl[i].e_rdata);
`ifdef DCACHE_PERF_EN
            if (i == 2) begin
                check("perf_hit_cnt", hit_cnt, 32'd3);
                check("perf_miss_cnt", miss_cnt, 32'd1);
            end
`endif
        end

        // Dirty a line, then reset in the middle of a fill: the fill and the dirty data are both lost.
        access(0, 1, 32'h2008, 32'hCAFEF00D, 2, rdata, miss, wb, wb_addr, wb_w1, cyc);
        m_access(32'h2008, 1, 32'hCAFEF00D, e_miss, e_wb, e_wb_addr);
        check("dirty_hit_miss", {31'd0, miss}, 32'd0);
        @(negedge clk);
        cpu_rd = 1'b1; cpu_addr = 32'h5040;
        @(negedge clk);
        #1;
        check("fill_req", {31'd0, mem_req}, 32'd1);
        check("fill_we", {31'd0, mem_we}, 32'd0);
        rst = 1'b1;
        #1;
        check("rstfill_memreq", {31'd0, mem_req}, 32'd0);
        check("rstfill_stall", {31'd0, cpu_stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0; cpu_rd = 1'b0;
        m_reset();
        access(1, 0, 32'h5040, 0, 2, rdata, miss, wb, wb_addr, wb_w1, cyc);
        m_access(32'h5040, 0, 0, e_miss, e_wb, e_wb_addr);
        check("reread_miss", {31'd0, miss}, 32'd1);
        check("reread_rdata", rdata, pattern(32'h5040));
        access(1, 0, 32'h2008, 0, 2, rdata, miss, wb, wb_addr, wb_w1, cyc);
        m_access(32'h2008, 0, 0, e_miss, e_wb, e_wb_addr);
        check("lost_dirty_miss", {31'd0, miss}, 32'd1);
        check("lost_dirty_rdata", rdata, pattern(32'h2008));

        for (int n = 0; n < 400; n++) begin
            a = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 3)) << 6)
              | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            d = $urandom;
            op = $urandom_range(0, 3);
            rd = (op != 2);
            wr = (op >= 2);
            lat = $urandom_range(1, 4);
            access(rd, wr, a, d, lat, rdata, miss, wb, wb_addr, wb_w1, cyc);
            if (rd && !wr) begin
                check($sformatf("rnd%0d_rdata@%h", n, a), rdata, vread(a & ~32'h3));
            end
            m_access(a, wr, d, e_miss, e_wb, e_wb_addr);
            check($sformatf("rnd%0d_miss@%h", n, a), {31'd0, miss}, {31'd0, e_miss});
            check($sformatf("rnd%0d_wb@%h", n, a), {31'd0, wb}, {31'd0, e_wb});
            if (e_wb) check($sformatf("rnd%0d_wb_addr", n), wb_addr, e_wb_addr);
            check($sformatf("rnd%0d_cycles", n), cyc, e_miss ? (1 + lat + (e_wb ? lat : 0)) : 0);
        end

`ifdef DCACHE_PERF_EN
        check("perf_hit_final", hit_cnt, m_hits);
        check("perf_miss_final", miss_cnt, m_misses);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
